seq_calculator: RTL and testbench
=================================

SEQ_CALCULATOR -- requirements
Module: seq_calculator

Interface
REQ-001 SHALL have parameter WIDTH, default 27: operand width in bits; legal range 4..32.
REQ-002 SHALL have parameter DIV_CYCLES, fixed at WIDTH: divider iterations, one quotient bit per cycle.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port data1, input, WIDTH bits: signed operand A.
REQ-006 SHALL have port data2, input, WIDTH bits: signed operand B.
REQ-007 SHALL have port en, input, 1 bit: start request; sampled on each rising clk edge.
REQ-008 SHALL have port arith, input, 3 bits: operation select; 000 add, 001 sub, 010 mul, 011 div, 100 square, 101-111 illegal.
REQ-009 SHALL have port data3, output, 2*WIDTH bits: signed result register.
REQ-010 SHALL have port data_latch, output, 1 bit: one-cycle pulse, high while a new data3 is first valid.
REQ-011 SHALL have port busy, output, 1 bit: high while an operation is in flight.
REQ-012 SHALL have port err, output, 1 bit: error flag for the latched result; valid with data_latch and held until the next latch.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, DIV, DONE; transitions: IDLE->EXEC on en with a non-div op; IDLE->DIV on en with op 011; EXEC->DONE; DIV->DONE after DIV_CYCLES iterations; DONE->IDLE.
REQ-014 SHALL capture data1, data2 and arith into internal registers at the accepting edge; later input changes do not affect the operation in flight.
REQ-015 SHALL accept en only in IDLE; en while busy is ignored, not queued.
REQ-016 SHALL raise busy at the accepting edge and drop it at the edge that enters DONE.
REQ-017 SHALL update data3 and err at the edge entering DONE and assert data_latch for exactly that one cycle.
REQ-018 SHALL hold data3 and err until the next DONE.
REQ-019 SHALL give add, sub, mul, square and illegal ops a latency of 2 edges from accept to data_latch high.
REQ-020 SHALL give div a latency of DIV_CYCLES+1 edges.
REQ-021 SHALL sign-extend add and sub results to 2*WIDTH bits; no overflow is possible.
REQ-022 SHALL produce mul as the full signed product data1*data2.
REQ-023 SHALL produce square as the full signed product data1*data1 (data2 ignored).
REQ-024 SHALL implement div as an iterative signed division truncating toward zero; data3 = {remainder, quotient}, each WIDTH bits, remainder taking the dividend's sign.
REQ-025 SHALL handle divide by zero with data3 = 0 and err = 1, reaching DONE on the next edge (latency 2).
REQ-026 SHALL handle div of -2^(WIDTH-1) by -1 with quotient = -2^(WIDTH-1), remainder = 0, err = 1.
REQ-027 SHALL treat illegal ops with data3 = 0 and err = 1.
REQ-028 SHALL permit back-to-back operation: en asserted in the DONE cycle is ignored, and en in the following IDLE cycle is accepted.

Reset
REQ-029 SHALL, while rst_n is low, asynchronously force state IDLE, data3 = 0, data_latch = 0, busy = 0, err = 0, and clear the divider registers.
REQ-030 SHALL abort any operation in flight, including mid-division, on rst_n assertion; no data_latch pulse follows for the aborted operation.
REQ-031 SHALL accept en on the first rising edge after rst_n deasserts.

Configuration
REQ-032 SHALL compile the divider in when macro SEQ_CALCULATOR_DIV_EN is defined; op 011 then behaves per REQ-024 to REQ-026.
REQ-033 SHALL, without SEQ_CALCULATOR_DIV_EN, contain no divider logic and no DIV state; op 011 is then treated as illegal (REQ-027, latency 2).

Structure
REQ-034 SHALL place the following in shared package calc_pkg: op-code constants (OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_SQR) and the FSM state typedef.
REQ-035 SHALL implement the iterative divider as the single sub-module seq_divider (start/done handshake, signed, parameter WIDTH); everything else stays in seq_calculator.

Verification (WIDTH=27, SEQ_CALCULATOR_DIV_EN defined unless noted)
REQ-036 SHALL cover add/sub: en with data1=100, data2=-250, op 000 -> data_latch 2 edges later, data3=-150, err=0; the same operands with op 001 -> data3=350.
REQ-037 SHALL cover mul/square: data1=-67108864, data2=-67108864, op 010 -> data3=4503599627370496; data1=-3, op 100 -> data3=9.
REQ-038 SHALL cover div: data1=-7, data2=2, op 011 -> busy for 27 edges, data_latch at edge 28, quotient=-3, remainder=-1, err=0; data2=0 -> data3=0, err=1 at latency 2.
REQ-039 SHALL cover ignored en and illegal op: en pulsed again during the division -> ignored, exactly one data_latch; op 110 -> data3=0, err=1.
REQ-040 SHALL cover reset mid-division: rst_n low at edge 10 of a division -> all outputs 0 immediately, no data_latch; a new add accepted on the first edge after release.
REQ-041 SHALL cover the macro-off build: without SEQ_CALCULATOR_DIV_EN, op 011 with data1=10, data2=2 -> err=1, data3=0, latency 2.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared op-codes and FSM state encoding for seq_calculator.
// The DIV state exists only when SEQ_CALCULATOR_DIV_EN is defined.
package calc_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_SQR = 3'b100;

`ifdef SEQ_CALCULATOR_DIV_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd3
  } state_t;
`endif

endpackage

// File: rtl/seq_divider.sv
// Iterative signed restoring divider, one quotient bit per clock.
// start loads operands; done is high during the cycle whose edge retires the last bit.
module seq_divider #(
  parameter int WIDTH = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH);

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_neg_q;
  logic             r_neg_r;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_fits;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic             w_last;

  // r_quo shifts the dividend out at the top while quotient bits enter at the bottom.
  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_dvs};
  assign w_fits     = ~w_diff[WIDTH];
  assign w_rem_next = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], w_fits};
  assign w_last     = r_busy && (r_cnt == CNT_W'(WIDTH - 1));

  assign done      = w_last;
  assign quotient  = r_neg_q ? (~w_quo_next + 1'b1) : w_quo_next;
  assign remainder = r_neg_r ? (~w_rem_next + 1'b1) : w_rem_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (start) begin
      r_rem   <= '0;
      r_quo   <= mag(dividend);
      r_dvs   <= mag(divisor);
      r_cnt   <= '0;
      r_busy  <= 1'b1;
      r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_neg_r <= dividend[WIDTH-1];
    end else if (r_busy) begin
      r_rem <= w_rem_next;
      r_quo <= w_quo_next;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_calculator.sv
// Sequential signed calculator: add/sub/mul/square in 2 edges, iterative divide
// compiled in only when SEQ_CALCULATOR_DIV_EN is defined.
module seq_calculator
  import calc_pkg::*;
#(
  parameter int WIDTH      = 27,
  parameter int DIV_CYCLES = WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   data1,
  input  logic [WIDTH-1:0]   data2,
  input  logic               en,
  input  logic [2:0]         arith,
  output logic [2*WIDTH-1:0] data3,
  output logic               data_latch,
  output logic               busy,
  output logic               err
);

  if (DIV_CYCLES != WIDTH || WIDTH < 4 || WIDTH > 32) begin : g_bad_cfg
    $error("seq_calculator: WIDTH must be 4..32 and DIV_CYCLES must equal WIDTH");
  end

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2:0]         r_op;
  logic [2*WIDTH-1:0] r_data3;
  logic               r_latch;
  logic               r_busy;
  logic               r_err;

  logic [2*WIDTH-1:0] w_ext_a;
  logic [2*WIDTH-1:0] w_ext_b;
  logic [2*WIDTH-1:0] w_exec_res;
  logic               w_exec_err;

  assign data3      = r_data3;
  assign data_latch = r_latch;
  assign busy       = r_busy;
  assign err        = r_err;

  // Sign-extending first keeps the low 2*WIDTH bits of every product exact.
  assign w_ext_a = {{WIDTH{r_a[WIDTH-1]}}, r_a};
  assign w_ext_b = {{WIDTH{r_b[WIDTH-1]}}, r_b};

  always_comb begin
    w_exec_res = '0;
    w_exec_err = 1'b0;
    case (r_op)
      OP_ADD:  w_exec_res = w_ext_a + w_ext_b;
      OP_SUB:  w_exec_res = w_ext_a - w_ext_b;
      OP_MUL:  w_exec_res = w_ext_a * w_ext_b;
      OP_SQR:  w_exec_res = w_ext_a * w_ext_a;
      default: w_exec_err = 1'b1;
    endcase
  end

`ifdef SEQ_CALCULATOR_DIV_EN
  logic             w_div_start;
  logic             w_div_done;
  logic [WIDTH-1:0] w_div_quo;
  logic [WIDTH-1:0] w_div_rem;
  logic             w_div_zero;
  logic             w_div_ovf;

  // Divide-by-zero never starts the divider; the DIV state retires it next edge.
  assign w_div_start = (r_state == ST_IDLE) && en && (arith == OP_DIV) && (data2 != '0);
  assign w_div_zero  = (r_b == '0);
  assign w_div_ovf   = (r_a == {1'b1, {(WIDTH-1){1'b0}}}) && (r_b == '1);

  seq_divider #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (w_div_start),
    .dividend  (data1),
    .divisor   (data2),
    .done      (w_div_done),
    .quotient  (w_div_quo),
    .remainder (w_div_rem)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_data3 <= '0;
      r_latch <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_latch <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (en) begin
            r_a    <= data1;
            r_b    <= data2;
            r_op   <= arith;
            r_busy <= 1'b1;
`ifdef SEQ_CALCULATOR_DIV_EN
            r_state <= (arith == OP_DIV) ? ST_DIV : ST_EXEC;
`else
            r_state <= ST_EXEC;
`endif
          end
        end
        ST_EXEC: begin
          r_data3 <= w_exec_res;
          r_err   <= w_exec_err;
          r_latch <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_DONE;
        end
`ifdef SEQ_CALCULATOR_DIV_EN
        ST_DIV: begin
          if (w_div_zero) begin
            r_data3 <= '0;
            r_err   <= 1'b1;
            r_latch <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end else if (w_div_done) begin
            r_data3 <= {w_div_rem, w_div_quo};
            r_err   <= w_div_ovf;
            r_latch <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end
        end
`endif
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_calculator.sv
// Directed self-checking bench for seq_calculator (WIDTH=27); expectations follow
// SEQ_CALCULATOR_DIV_EN so the same bench covers both builds.
module tb_seq_calculator;
  import calc_pkg::*;

  localparam int W = 27;
`ifdef SEQ_CALCULATOR_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic [W-1:0]   data1 = '0;
  logic [W-1:0]   data2 = '0;
  logic [2:0]     arith = '0;
  logic [2*W-1:0] data3;
  logic           data_latch;
  logic           busy;
  logic           err;

  int n_cmp = 0;
  int n_bad = 0;
  int latch_cnt = 0;

  seq_calculator #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data1      (data1),
    .data2      (data2),
    .en         (en),
    .arith      (arith),
    .data3      (data3),
    .data_latch (data_latch),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (data_latch) latch_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Called at a negedge with the DUT idle; returns at the first negedge after DONE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                        input int pulse_edge, output int lat, output int busy_cycles);
    data1 = a; data2 = b; arith = op; en = 1'b1;
    @(posedge clk); lat = 1; busy_cycles = 0;
    @(negedge clk); en = 1'b0;
    while (!data_latch && lat < 100) begin
      if (busy) busy_cycles++;
      if (lat == pulse_edge) begin
        en = 1'b1; data1 = 1; data2 = 1; arith = OP_ADD;
      end
      @(posedge clk); lat++;
      @(negedge clk); en = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_cmp++; if (data3 !== '0) begin n_bad++; $display("FAIL reset_data3: got %h want 0", data3); end
    n_cmp++; if (data_latch !== 1'b0) begin n_bad++; $display("FAIL reset_latch: got %b want 0", data_latch); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_sub;
    int lat, bc;
    logic [2*W-1:0] exp;
    run_op(100, -250, OP_ADD, 0, lat, bc);
    exp = -150;
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL add_latency: got %0d want 2", lat); end
    n_cmp++; if (data3 !== exp) begin n_bad++; $display("FAIL add_data3: got %0d want %0d", $signed(data3), $signed(exp)); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL add_err: got %b want 0", err); end
    $display("add 100 + -250 -> %0d err=%b lat=%0d", $signed(data3), err, lat);
    run_op(100, -250, OP_SUB, 0, lat, bc);
    exp = 350;
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL sub_latency: got %0d want 2", lat); end
    n_cmp++; if (data3 !== exp) begin n_bad++; $display("FAIL sub_data3: got %0d want %0d", $signed(data3), $signed(exp)); end
    $display("sub 100 - -250 -> %0d err=%b lat=%0d", $signed(data3), err, lat);
  endtask

  task automatic test_mul_sqr;
    int lat, bc;
    logic [2*W-1:0] exp;
    run_op(-67108864, -67108864, OP_MUL, 0, lat, bc);
    exp = 54'd4503599627370496;
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL mul_latency: got %0d want 2", lat); end
    n_cmp++; if (data3 !== exp) begin n_bad++; $display("FAIL mul_data3: got %0d want %0d", $signed(data3), $signed(exp)); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL mul_err: got %b want 0", err); end
    $display("mul -2^26 * -2^26 -> %0d err=%b lat=%0d", $signed(data3), err, lat);
    run_op(-3, 5, OP_SQR, 0, lat, bc);
    exp = 9;
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL sqr_latency: got %0d want 2", lat); end
    n_cmp++; if (data3 !== exp) begin n_bad++; $display("FAIL sqr_data3: got %0d want %0d", $signed(data3), $signed(exp)); end
    $display("sqr -3 -> %0d err=%b lat=%0d", $signed(data3), err, lat);
  endtask

  task automatic test_illegal;
    int lat, bc;
    run_op(5, 5, 3'b110, 0, lat, bc);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL illegal_latency: got %0d want 2", lat); end
    n_cmp++; if (data3 !== '0) begin n_bad++; $display("FAIL illegal_data3: got %h want 0", data3); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL illegal_err: got %b want 1", err); end
    $display("illegal op 110 -> %0d err=%b lat=%0d", $signed(data3), err, lat);
  endtask

  task automatic test_div;
    int lat, bc;
    logic [W-1:0] q, r;
    logic [2*W-1:0] exp;
    if (DIV_EN) begin
      run_op(-7, 2, OP_DIV, 0, lat, bc);
      q = -3; r = -1; exp = {r, q};
      n_cmp++; if (lat !== 28) begin n_bad++; $display("FAIL div_latency: got %0d want 28", lat); end
      n_cmp++; if (bc !== 27) begin n_bad++; $display("FAIL div_busy_cycles: got %0d want 27", bc); end
      n_cmp++; if (data3 !== exp) begin n_bad++; $display("FAIL div_data3: got %h want %h", data3, exp); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL div_err: got %b want 0", err); end
      $display("div -7 / 2 -> data3=%h err=%b lat=%0d busy=%0d", data3, err, lat, bc);
      run_op(27'h4000000, -1, OP_DIV, 0, lat, bc);
      q = 27'h4000000; r = '0; exp = {r, q};
      n_cmp++; if (lat !== 28) begin n_bad++; $display("FAIL divovf_latency: got %0d want 28", lat); end
      n_cmp++; if (data3 !== exp) begin n_bad++; $display("FAIL divovf_data3: got %h want %h", data3, exp); end
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL divovf_err: got %b want 1", err); end
      $display("div -2^26 / -1 -> data3=%h err=%b lat=%0d", data3, err, lat);
      run_op(-7, 0, OP_DIV, 0, lat, bc);
    end else begin
      run_op(1, 2, OP_ADD, 0, lat, bc);
      run_op(10, 2, OP_DIV, 0, lat, bc);
    end
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL div_err_latency: got %0d want 2", lat); end
    n_cmp++; if (data3 !== '0) begin n_bad++; $display("FAIL div_err_data3: got %h want 0", data3); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL div_err_flag: got %b want 1", err); end
    $display("div error case -> data3=%h err=%b lat=%0d", data3, err, lat);
  endtask

  task automatic test_ignored_en;
    int lat, bc, base;
    logic [W-1:0] q, r;
    logic [2*W-1:0] exp;
    base = latch_cnt;
    if (DIV_EN) begin
      run_op(100, -7, OP_DIV, 4, lat, bc);
      q = -14; r = 2; exp = {r, q};
      n_cmp++; if (lat !== 28) begin n_bad++; $display("FAIL ign_latency: got %0d want 28", lat); end
    end else begin
      run_op(6, 7, OP_MUL, 1, lat, bc);
      exp = 42;
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL ign_latency: got %0d want 2", lat); end
    end
    repeat (5) @(negedge clk);
    n_cmp++; if (data3 !== exp) begin n_bad++; $display("FAIL ign_data3: got %h want %h", data3, exp); end
    n_cmp++; if (latch_cnt - base !== 1) begin n_bad++; $display("FAIL ign_latch_count: got %0d want 1", latch_cnt - base); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ign_busy_after: got %b want 0", busy); end
    $display("ignored en -> data3=%h latches=%0d lat=%0d", data3, latch_cnt - base, lat);
  endtask

  task automatic test_back_to_back;
    logic [2*W-1:0] exp;
    data1 = 5; data2 = 6; arith = OP_MUL; en = 1'b1;
    @(posedge clk); @(negedge clk); en = 1'b0;
    @(posedge clk); @(negedge clk);
    exp = 30;
    n_cmp++; if (data_latch !== 1'b1) begin n_bad++; $display("FAIL b2b_first_latch: got %b want 1", data_latch); end
    n_cmp++; if (data3 !== exp) begin n_bad++; $display("FAIL b2b_first_data3: got %0d want 30", $signed(data3)); end
    data1 = 5; data2 = 6; arith = OP_ADD; en = 1'b1;
    @(posedge clk); @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL b2b_done_en_ignored: got busy %b want 0", busy); end
    n_cmp++; if (data_latch !== 1'b0) begin n_bad++; $display("FAIL b2b_latch_pulse: got %b want 0", data_latch); end
    @(posedge clk); @(negedge clk); en = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_second_accept: got busy %b want 1", busy); end
    @(posedge clk); @(negedge clk);
    exp = 11;
    n_cmp++; if (data_latch !== 1'b1) begin n_bad++; $display("FAIL b2b_second_latch: got %b want 1", data_latch); end
    n_cmp++; if (data3 !== exp) begin n_bad++; $display("FAIL b2b_second_data3: got %0d want 11", $signed(data3)); end
    $display("back-to-back mul 5*6 then add 5+6 -> %0d", $signed(data3));
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int base;
    logic [2*W-1:0] exp;
    data1 = -7; data2 = 2; arith = DIV_EN ? OP_DIV : OP_MUL; en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    repeat (DIV_EN ? 9 : 0) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
    base = latch_cnt;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (data3 !== '0) begin n_bad++; $display("FAIL rstmid_data3: got %h want 0", data3); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_cmp++; if (data_latch !== 1'b0) begin n_bad++; $display("FAIL rstmid_latch: got %b want 0", data_latch); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rstmid_err: got %b want 0", err); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    data1 = 3; data2 = 4; arith = OP_ADD; en = 1'b1;
    @(posedge clk); @(negedge clk); en = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_accept: got busy %b want 1", busy); end
    @(posedge clk); @(negedge clk);
    exp = 7;
    n_cmp++; if (data_latch !== 1'b1) begin n_bad++; $display("FAIL rstmid_add_latch: got %b want 1", data_latch); end
    n_cmp++; if (data3 !== exp) begin n_bad++; $display("FAIL rstmid_add_data3: got %0d want 7", $signed(data3)); end
    repeat (40) @(negedge clk);
    n_cmp++; if (latch_cnt - base !== 1) begin n_bad++; $display("FAIL rstmid_latch_count: got %0d want 1", latch_cnt - base); end
    $display("reset mid-op then add 3+4 -> %0d latches=%0d", $signed(data3), latch_cnt - base);
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul_sqr();
    test_illegal();
    test_div();
    test_ignored_en();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
